// File: rtl/jtframe_mcu_pkg.sv
// Shared definitions for the MCU ROM server: refill FSM encoding and byte-lane selection.
package jtframe_mcu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    // rom_addr[0] value that selects the upper byte of a 16-bit ROM word
    localparam logic HI_BYTE = 1'b1;

    function automatic logic [7:0] byte_lane(input logic [15:0] word, input logic sel);
        return (sel == HI_BYTE) ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/jtframe_mcu_romserve_line.sv
// One entry of the MCU ROM word cache: valid bit, tag, 16-bit word, hit compare and byte mux.
module jtframe_mcu_romserve_line
    import jtframe_mcu_pkg::*;
#(
    parameter int TW = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          wr,
    input  logic          wr_vld,
    input  logic [TW-1:0] wr_tag,
    input  logic [15:0]   wr_data,
    input  logic [TW-1:0] tag,
    input  logic          sel,
    output logic          hit,
    output logic [7:0]    dout
);

    logic          valid;
    logic [TW-1:0] tag_r;
    logic [15:0]   data_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid  <= 1'b0;
            tag_r  <= '0;
            data_r <= '0;
        end else begin
            if (wr) begin
                tag_r  <= wr_tag;
                data_r <= wr_data;
            end
            // Invalidation wins over a fill landing in the same cycle
            if (clr)
                valid <= 1'b0;
            else if (wr)
                valid <= wr_vld;
        end
    end

    assign hit  = valid && (tag_r == tag);
    assign dout = hit ? byte_lane(data_r, sel) : 8'h00;

endmodule

// File: rtl/jtframe_mcu_romserve.sv
// MCU ROM fetch responder: two-entry word cache with LRU replacement, refilled from an SDRAM slot.
module jtframe_mcu_romserve
    import jtframe_mcu_pkg::*;
#(
    parameter int              ROMW   = 12,
    parameter int              SDW    = 22,
    parameter logic [SDW-1:0]  OFFSET = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            rom_cs,
    input  logic [ROMW-1:0] rom_addr,
    output logic [7:0]      rom_data,
    output logic            rom_ok,
    output logic            sdram_req,
    output logic [SDW-1:0]  sdram_addr,
    input  logic            sdram_ack,
    input  logic            sdram_rdy,
    input  logic [15:0]     sdram_data
);

    localparam int TW = ROMW - 1;

    state_t        state, state_nx;
    logic [TW-1:0] tag, req_tag;
    logic          sel;
    logic          hit0, hit1, hit0_e, hit1_e, hit;
    logic [7:0]    dout0, dout1;
    logic          lru, victim, poison;
    logic          start, fill, wr_vld;

    assign tag = rom_addr[ROMW-1:1];
    assign sel = rom_addr[0];

    jtframe_mcu_romserve_line #(.TW(TW)) u_line0 (
        .clk     (clk),
        .rst     (rst),
        .clr     (flush),
        .wr      (fill && !victim),
        .wr_vld  (wr_vld),
        .wr_tag  (req_tag),
        .wr_data (sdram_data),
        .tag     (tag),
        .sel     (sel),
        .hit     (hit0),
        .dout    (dout0)
    );

    jtframe_mcu_romserve_line #(.TW(TW)) u_line1 (
        .clk     (clk),
        .rst     (rst),
        .clr     (flush),
        .wr      (fill && victim),
        .wr_vld  (wr_vld),
        .wr_tag  (req_tag),
        .wr_data (sdram_data),
        .tag     (tag),
        .sel     (sel),
        .hit     (hit1),
        .dout    (dout1)
    );

    // A flush hides the cache immediately, before the valid bits clear at the edge
    assign hit0_e   = hit0 && !flush;
    assign hit1_e   = hit1 && !flush;
    assign hit      = hit0_e || hit1_e;
    assign rom_ok   = rom_cs && hit;
    assign rom_data = hit0_e ? dout0 : (hit1_e ? dout1 : 8'h00);

    assign start  = (state == IDLE) && rom_cs && !hit && !flush;
    assign fill   = ((state == WAIT) && sdram_rdy) ||
                    ((state == REQ) && sdram_ack && sdram_rdy);
    assign wr_vld = !(poison || flush);

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = REQ;
            REQ:  if (sdram_ack) state_nx = sdram_rdy ? IDLE : WAIT;
            WAIT: if (sdram_rdy) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        sdram_req = (state == REQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_tag    <= '0;
            sdram_addr <= '0;
            victim     <= 1'b0;
            lru        <= 1'b0;
            poison     <= 1'b0;
        end else begin
            if (start) begin
                req_tag    <= tag;
                sdram_addr <= OFFSET + SDW'(tag);
                victim     <= lru;
            end
            if (fill)
                lru <= ~victim;
            else if (rom_cs && hit0_e)
                lru <= 1'b1;
            else if (rom_cs && hit1_e)
                lru <= 1'b0;
            // Poison lives only while a refill is outstanding
            poison <= (state != IDLE) && (state_nx != IDLE) && (poison || flush);
        end
    end

endmodule

// File: tb/tb_jtframe_mcu_romserve.sv
// Directed bench for jtframe_mcu_romserve: the bench plays the SDRAM slot and checks hand-computed results.
module tb_jtframe_mcu_romserve;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        rom_cs = 1'b0;
    logic [11:0] rom_addr = '0;
    logic [7:0]  rom_data;
    logic        rom_ok;
    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic        sdram_ack = 1'b0;
    logic        sdram_rdy = 1'b0;
    logic [15:0] sdram_data = '0;

    int checks = 0;
    int errors = 0;

    jtframe_mcu_romserve #(
        .ROMW   (12),
        .SDW    (22),
        .OFFSET (22'h3000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .rom_cs     (rom_cs),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .rom_ok     (rom_ok),
        .sdram_req  (sdram_req),
        .sdram_addr (sdram_addr),
        .sdram_ack  (sdram_ack),
        .sdram_rdy  (sdram_rdy),
        .sdram_data (sdram_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // Present a missing address, wait for the request and serve it
    task automatic fill_miss(input logic [11:0] a, input logic [15:0] d, input logic [21:0] exp_sa,
                             input int ack_w, input int rdy_w, input bit both);
        int n;
        rom_cs   = 1'b1;
        rom_addr = a;
        n = 0;
        while (!sdram_req && n < 8) begin
            tick;
            n++;
        end
        check("req_up", sdram_req, 1);
        check("req_addr", sdram_addr, exp_sa);
        repeat (ack_w) begin
            tick;
            check("req_hold", sdram_req, 1);
            check("req_addr_hold", sdram_addr, exp_sa);
        end
        sdram_ack = 1'b1;
        if (both) begin
            sdram_rdy  = 1'b1;
            sdram_data = d;
        end
        tick;
        sdram_ack = 1'b0;
        sdram_rdy = 1'b0;
        if (!both) begin
            check("req_drop", sdram_req, 0);
            repeat (rdy_w) begin
                check("ok_wait", rom_ok, 0);
                tick;
            end
            sdram_rdy  = 1'b1;
            sdram_data = d;
            tick;
            sdram_rdy = 1'b0;
        end
        #1;
        check("fill_ok", rom_ok, 1);
        check("fill_data", rom_data, a[0] ? d[15:8] : d[7:0]);
    endtask

    initial begin
        // Reset state
        tick; tick;
        rst = 1'b0;
        tick;
        check("rst_ok", rom_ok, 0);
        check("rst_data", rom_data, 0);
        check("rst_req", sdram_req, 0);
        check("rst_addr", sdram_addr, 0);
        rom_cs = 1'b1;
        rom_addr = 12'h000;
        #1;
        check("rst_tag0_miss", rom_ok, 0);

        // Cold miss at the top of ROM
        rom_addr = 12'hFFE;
        #1;
        check("cold_miss_ok", rom_ok, 0);
        check("cold_miss_data", rom_data, 0);
        fill_miss(12'hFFE, 16'hA55A, 22'h37FF, 2, 2, 0);
        rom_addr = 12'hFFF;
        #1;
        check("cold_hi_ok", rom_ok, 1);
        check("cold_hi_data", rom_data, 8'hA5);
        tick;
        check("cold_no_req", sdram_req, 0);

        // Two-way reuse with LRU replacement
        flush = 1'b1;
        tick;
        flush = 1'b0;
        fill_miss(12'h010, 16'hB010, 22'h3008, 1, 1, 0);
        fill_miss(12'h020, 16'hB020, 22'h3010, 0, 0, 0);
        rom_addr = 12'h010;
        #1;
        check("lru_touch_ok", rom_ok, 1);
        check("lru_touch_data", rom_data, 8'h10);
        tick;
        fill_miss(12'h030, 16'hB030, 22'h3018, 0, 0, 0);
        rom_addr = 12'h011;
        #1;
        check("lru_keep_ok", rom_ok, 1);
        check("lru_keep_data", rom_data, 8'hB0);
        rom_addr = 12'h020;
        #1;
        check("lru_evict_ok", rom_ok, 0);
        fill_miss(12'h020, 16'hB020, 22'h3010, 0, 0, 0);

        // Simultaneous ack and rdy
        fill_miss(12'h050, 16'h5EE5, 22'h3028, 1, 0, 1);
        repeat (3) begin
            tick;
            check("both_no_req", sdram_req, 0);
            check("both_ok", rom_ok, 1);
        end

        // Address change while the refill is outstanding
        rom_addr = 12'h100;
        tick;
        check("mid_req", sdram_req, 1);
        check("mid_addr", sdram_addr, 22'h3080);
        sdram_ack = 1'b1;
        tick;
        sdram_ack = 1'b0;
        rom_addr = 12'h200;
        #1;
        check("mid_wait_ok", rom_ok, 0);
        tick;
        check("mid_wait_ok2", rom_ok, 0);
        check("mid_wait_req", sdram_req, 0);
        sdram_rdy  = 1'b1;
        sdram_data = 16'hC1CD;
        tick;
        sdram_rdy = 1'b0;
        #1;
        check("mid_other_ok", rom_ok, 0);
        check("mid_other_data", rom_data, 0);
        fill_miss(12'h200, 16'hC2AB, 22'h3100, 0, 1, 0);
        rom_addr = 12'h100;
        #1;
        check("mid_first_ok", rom_ok, 1);
        check("mid_first_data", rom_data, 8'hCD);

        // Flush pulse while waiting for rdy poisons the refill
        rom_addr = 12'h300;
        tick;
        check("fl_req_addr", sdram_addr, 22'h3180);
        sdram_ack = 1'b1;
        tick;
        sdram_ack = 1'b0;
        flush = 1'b1;
        rom_addr = 12'h100;
        #1;
        check("fl_gate_ok", rom_ok, 0);
        tick;
        flush = 1'b0;
        #1;
        check("fl_cleared_ok", rom_ok, 0);
        rom_addr = 12'h300;
        tick;
        sdram_rdy  = 1'b1;
        sdram_data = 16'h1234;
        tick;
        sdram_rdy = 1'b0;
        #1;
        check("fl_poison_ok", rom_ok, 0);
        tick;
        check("fl_rereq", sdram_req, 1);
        check("fl_rereq_addr", sdram_addr, 22'h3180);
        fill_miss(12'h300, 16'h1234, 22'h3180, 0, 0, 1);

        // Flush held in IDLE blocks new requests
        flush = 1'b1;
        rom_addr = 12'h500;
        tick; tick;
        check("fl_idle_req", sdram_req, 0);
        check("fl_idle_ok", rom_ok, 0);
        flush = 1'b0;
        tick;
        check("fl_after_req", sdram_req, 1);
        fill_miss(12'h500, 16'h5566, 22'h3280, 1, 1, 0);

        // Reset while a request is pending
        rom_addr = 12'h600;
        tick;
        check("rr_req", sdram_req, 1);
        rst = 1'b1;
        tick;
        check("rr_req_drop", sdram_req, 0);
        rst = 1'b0;
        rom_cs = 1'b0;
        tick;
        check("rr_idle_req", sdram_req, 0);
        check("rr_addr", sdram_addr, 0);
        sdram_rdy  = 1'b1;
        sdram_data = 16'hFFFF;
        tick;
        sdram_rdy = 1'b0;
        rom_cs = 1'b1;
        rom_addr = 12'h600;
        #1;
        check("rr_stray_ok", rom_ok, 0);
        rom_addr = 12'h500;
        #1;
        check("rr_cleared_ok", rom_ok, 0);
        rom_cs = 1'b0;
        tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtframe_mcu_romserve.md
Name: jtframe_mcu_romserve

Overview:
- Responder end of the MCU ROM fetch interface (rom_cs / rom_addr / rom_data / rom_ok) used by the 63701-style MCU wrappers.
- Serves MCU opcode and data fetches from a two-entry, 16-bit-word cache.
- Refills misses from the SDRAM ROM slot through a req/ack/rdy handshake.
- Sits between the MCU wrapper and the SDRAM controller slot. The MCU stalls via its wait-cen logic until rom_ok.

Parameters:
- ROMW, 12: MCU ROM byte-address width.
- SDW, 22: SDRAM word-address width.
- OFFSET, 22'h0: SDRAM word address of MCU ROM byte 0.

Ports:
- clk  in  1: system clock.
- rst  in  1: reset.
- flush  in  1: invalidate cache (ROM download in progress).
- rom_cs  in  1: MCU ROM access strobe.
- rom_addr  in  ROMW: MCU byte address.
- rom_data  out  8: byte for rom_addr.
- rom_ok  out  1: rom_data valid for current rom_addr.
- sdram_req  out  1: refill request, held until ack.
- sdram_addr  out  SDW: word address of refill.
- sdram_ack  in  1: controller accepted request.
- sdram_rdy  in  1: sdram_data valid, one cycle.
- sdram_data  in  16: refill word.

Behaviour:
- Reset is synchronous, active-high, on rst; clock is clk. At reset:
  - both valid bits = 0, tags = 0, data = 0, lru = 0;
  - state IDLE, sdram_req = 0, sdram_addr = 0;
  - rom_ok = 0, rom_data = 0.
- Tag is rom_addr[ROMW-1:1].
- hitN = validN && tagN == tag. hit = hit0 | hit1.
- rom_ok = rom_cs && hit, combinational from registered cache state. A hit therefore costs zero added cycles.
- rom_data is combinational:
  - hit entry, low byte [7:0] when rom_addr[0] = 0, high byte [15:8] when 1;
  - 0 on miss.
- lru names the victim entry. On any cycle with rom_cs && hitN, lru <= ~N.
- FSM IDLE:
  - if rom_cs && !hit && !flush: latch req_tag = tag, sdram_addr = OFFSET + tag (zero-extended, modulo 2^SDW), victim = lru, sdram_req = 1; go REQ.
- FSM REQ:
  - hold sdram_req and sdram_addr stable until sdram_ack.
  - on ack: sdram_req <= 0; go WAIT.
  - ack and rdy in the same cycle: treat as WAIT completion directly (fill now), go IDLE.
- FSM WAIT:
  - on sdram_rdy: data[victim] <= sdram_data, tag[victim] <= req_tag, valid[victim] <= 1 unless the request is poisoned, lru <= ~victim; go IDLE.
  - rom_ok may rise the cycle after rdy.
- sdram_rdy outside WAIT, or outside REQ with ack, is ignored.
- rom_cs dropped or rom_addr changed mid-refill:
  - the refill is never cancelled; it completes and fills req_tag;
  - a new miss is issued from IDLE afterwards.
- flush:
  - clears both valid bits the same cycle; rom_ok = 0 while flush is high;
  - if asserted in REQ/WAIT, sets poison. The in-flight word is discarded on rdy (valid stays 0) and poison clears on return to IDLE;
  - no new request starts while flush is high.
- Latency, miss to rom_ok: 1 (IDLE→REQ) + controller ack delay + rdy delay + 1 cycle.
- Tag comparison covers the full ROMW-1 bits. Address wrap-around at the top of ROM needs no special case.
- Reset mid-refill: FSM forced to IDLE, req dropped. A later stray rdy is ignored.

Decomposition:
- Shared package jtframe_mcu_pkg holds:
  - FSM state encoding (IDLE=2'd0, REQ=2'd1, WAIT=2'd2);
  - the byte-lane select constant.
- One sub-module, jtframe_mcu_romserve_line, is natural: it holds a single cache entry (valid, tag, data, hit, byte mux) and is instantiated twice.
- FSM, LRU and SDRAM handshake stay in the top module.

Test Plan:
- Cold miss: after reset, rom_cs = 1, rom_addr = 12'hFFE, ack after 2 cycles, rdy with 16'hA55A 3 cycles later.
  - sdram_req held, sdram_addr = OFFSET + 11'h7FF.
  - rom_ok rises, rom_data = 8'h5A.
  - Then rom_addr = 12'hFFF gives rom_ok the same cycle, rom_data = 8'hA5, no new req.
- Two-way reuse: fill tags 0x010 and 0x020, then touch 0x010; a miss at 0x030 replaces the 0x020 entry.
  - 0x010 still hits, 0x020 now misses.
- Simultaneous ack+rdy in one cycle: the fill completes; exactly one request is issued, and rom_ok follows.
- Address change mid-refill: rom_addr moves from 0x100 to 0x200 while in WAIT.
  - Entry 0x100 is filled; a second request for 0x200 follows.
  - rom_ok is never asserted with 0x100 data on 0x200.
- flush during WAIT: rdy arrives.
  - Both entries stay invalid and rom_ok stays 0.
  - After flush falls, the same address re-requests.
- rst asserted in REQ: sdram_req drops next cycle; a subsequent stray rdy leaves valid = 0.
